booth_encoder_seq: RTL and testbench
====================================

// Module: booth_encoder_seq
// PURPOSE
//  Sequential radix-4 Booth encoder: the producer side of the Single/Double/Negative selector interface.
//  Latches an N-bit two's-complement multiplier X and emits one Booth digit per handshake, LSB group first.
//  There are N/2 digits in total, each with its group index. A booth selector plus accumulator consumes the digits.
// PARAMETERS
//  N   32   multiplier width; must be even and >= 4
//  IW  $clog2(N/2)   width of the Index output (derived; do not override)
// PORTS
//  clk       in   1   clock, rising edge
//  rst       in   1   asynchronous, active-high reset
//  start     in   1   one-cycle request to encode X; honoured only while IDLE
//  X         in   N   multiplier (signed), sampled on the cycle start is accepted
//  busy      out  1   high from the cycle after start is accepted until done
//  enc_valid out  1   Single/Double/Negative/Index/Last are valid
//  enc_ready in   1   consumer accepts the current digit
//  Single    out  1   digit magnitude is 1
//  Double    out  1   digit magnitude is 2
//  Negative  out  1   digit is negative (Negative=1 with Single=Double=0 means -0)
//  Index     out  IW  group number i (0..N/2-1); the digit weight is 4^i
//  Last      out  1   current digit is group N/2-1
//  done      out  1   one-cycle pulse after the Last digit is accepted
// BEHAVIOUR
//  - Reset (async, any state, including mid-operation): state=IDLE. All outputs are 0. The shift register and Index are cleared.
//  - Shift register sreg[N:0]. On start in IDLE: sreg <= {X,1'b0}, Index <= 0, state -> ENCODE.
//  - Triplet t = sreg[2:0] = {x[2i+1], x[2i], x[2i-1]}. Encoding:
//    000 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1, 111 -> -0.
//    Single = t[1]^t[0]. Double = (t==011)|(t==100). Negative = t[2].
//  - States: IDLE -> ENCODE (on start) -> DONE (after the Last transfer) -> IDLE (next cycle).
//    The DONE state drives done=1 and busy=0.
//  - ENCODE: enc_valid=1. While enc_ready=0, all digit outputs hold stable.
//    On enc_valid & enc_ready: sreg <= sreg >> 2 (fill with 0), Index <= Index+1.
//  - Last = (Index == N/2-1). The top group uses x[N-1], x[N-2], x[N-3], so no sign extension is needed.
//  - Latency: first digit is valid 1 cycle after start. Minimum N/2 cycles of digits when enc_ready=1. done follows 1 cycle after the Last transfer.
//  - start while busy or in DONE is ignored; X is not re-sampled.
//  - Outputs Single, Double and Negative are forced to 0 whenever enc_valid=0.
// CONFIGURATION
//  ZERO_SKIP_EN defined:
//   - A group encoding 0 or -0 (t=000/111) is consumed internally: shift and Index+1 happen with enc_valid=0 for that cycle.
//   - Exception: the Last group is always presented, so the consumer always sees Last.
//   - Index still reports the true group number.
//  ZERO_SKIP_EN undefined: every one of the N/2 groups is presented.
// STRUCTURE
//  - Package booth_pkg: state_t enum {IDLE, ENCODE, DONE}; struct booth_code_t {single, double, negative}; localparam BOOTH_RADIX_BITS=2.
//  - Sub-module booth_enc_cell: combinational 3-bit triplet -> booth_code_t. Reusable by a future parallel encoder.
// TESTING
//  - Reset: assert rst mid-ENCODE (X=10, Index=1) -> next edge-independent: busy=0, enc_valid=0, Index=0, all outputs 0.
//  - X=10 (0x0000000A), enc_ready=1 -> i0:D,N; i1:S,N; i2:S; i3..i15:0. Last at i15. done 1 cycle later. Sum of digits = 10.
//  - X=0xFFFFFFFF -> i0:S,N; i1..i15:Negative=1 only (-0). With ZERO_SKIP_EN only Index 0 and 15 are presented.
//  - X=0x80000000 -> i0..i14 zero; i15: D,N, Last=1 (value -2^31).
//  - Backpressure: X=10, enc_ready low for 3 cycles at i1 -> outputs hold S,N,Index=1 unchanged; resume on enc_ready.
//  - start pulsed while busy with a different X -> ignored; digits continue from the original X; done fires once.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit decode for the Booth encoder family.
// Used by booth_enc_cell and booth_encoder_seq.
package booth_pkg;

  localparam int BOOTH_RADIX_BITS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENCODE = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef struct packed {
    logic single;
    logic double;
    logic negative;
  } booth_code_t;

  // t = {x[2i+1], x[2i], x[2i-1]}
  function automatic booth_code_t booth_decode(input logic [2:0] t);
    booth_code_t c;
    c.single   = t[1] ^ t[0];
    c.double   = (t == 3'b011) | (t == 3'b100);
    c.negative = t[2];
    return c;
  endfunction

  function automatic logic booth_is_zero(input logic [2:0] t);
    return (t == 3'b000) | (t == 3'b111);
  endfunction

endpackage

// File: rtl/booth_enc_cell.sv
// Combinational radix-4 Booth cell: one overlapping triplet in, one Single/Double/Negative code out.
// Kept standalone so a parallel encoder can instantiate one per group.
module booth_enc_cell
  import booth_pkg::*;
(
  input  logic [2:0]  triplet,
  output booth_code_t code
);

  assign code = booth_decode(triplet);

endmodule

// File: rtl/booth_encoder_seq.sv
// Sequential radix-4 Booth encoder: latches X and hands out one digit per enc_valid/enc_ready transfer.
// Optional macro ZERO_SKIP_EN: zero-valued groups (except the last) are consumed without being presented.
module booth_encoder_seq
  import booth_pkg::*;
#(
  parameter int N  = 32,
  parameter int IW = $clog2(N/2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  X,
  output logic          busy,
  output logic          enc_valid,
  input  logic          enc_ready,
  output logic          Single,
  output logic          Double,
  output logic          Negative,
  output logic [IW-1:0] Index,
  output logic          Last,
  output logic          done
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N/2 - 1);

  state_t        state_q, state_d;
  logic [N:0]    sreg_q, sreg_d;
  logic [IW-1:0] index_q, index_d;

  booth_code_t   code_s;
  logic          last_s;
  logic          skip_s;
  logic          present_s;
  logic          advance_s;

  booth_enc_cell u_cell (
    .triplet (sreg_q[2:0]),
    .code    (code_s)
  );

  assign last_s = (index_q == LAST_IDX);

  // Decide whether the current group is shown to the consumer or silently consumed
  always_comb begin
`ifdef ZERO_SKIP_EN
    skip_s = (state_q == ENCODE) && booth_is_zero(sreg_q[2:0]) && !last_s;
`else
    skip_s = 1'b0;
`endif
    present_s = (state_q == ENCODE) && !skip_s;
    advance_s = (state_q == ENCODE) && (skip_s || enc_ready);
  end

  // State, shift register and group index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      index_q <= index_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE so X is never re-sampled mid-operation
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d  = {X, 1'b0};
          index_d = '0;
          state_d = ENCODE;
        end else begin
          state_d = IDLE;
        end
      end
      ENCODE: begin
        if (advance_s) begin
          sreg_d  = sreg_q >> BOOTH_RADIX_BITS;
          index_d = index_q + IW'(1);
          if (last_s) begin
            state_d = DONE;
          end else begin
            state_d = ENCODE;
          end
        end else begin
          state_d = ENCODE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs; the digit code is masked whenever no digit is being presented
  always_comb begin
    busy      = (state_q == ENCODE);
    done      = (state_q == DONE);
    enc_valid = present_s;
    Single    = present_s & code_s.single;
    Double    = present_s & code_s.double;
    Negative  = present_s & code_s.negative;
    Index     = index_q;
    Last      = (state_q == ENCODE) & last_s;
  end

endmodule

// File: tb/tb_booth_encoder_seq.sv
// Self-checking bench for booth_encoder_seq: table of hand-computed digits plus reset,
// backpressure and start-while-busy sequences. Honours ZERO_SKIP_EN when compiled with it.
module tb_booth_encoder_seq;

  localparam int N  = 32;
  localparam int IW = 4;
  localparam int G  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  X;
  logic          busy;
  logic          enc_valid;
  logic          enc_ready;
  logic          Single;
  logic          Double;
  logic          Negative;
  logic [IW-1:0] Index;
  logic          Last;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic cap_p [G];
  logic cap_s [G];
  logic cap_d [G];
  logic cap_n [G];

  typedef struct {
    logic [31:0] x;
    int          idx;
    logic        s;
    logic        d;
    logic        n;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  booth_encoder_seq #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .X         (X),
    .busy      (busy),
    .enc_valid (enc_valid),
    .enc_ready (enc_ready),
    .Single    (Single),
    .Double    (Double),
    .Negative  (Negative),
    .Index     (Index),
    .Last      (Last),
    .done      (done)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},      longint'(busy),      0);
    chk({tag, "_enc_valid"}, longint'(enc_valid), 0);
    chk({tag, "_single"},    longint'(Single),    0);
    chk({tag, "_double"},    longint'(Double),    0);
    chk({tag, "_negative"},  longint'(Negative),  0);
    chk({tag, "_index"},     longint'(Index),     0);
    chk({tag, "_last"},      longint'(Last),      0);
    chk({tag, "_done"},      longint'(done),      0);
  endtask

  // Run one full encode with enc_ready=1, capturing every presented digit.
  // Optionally pulses start with poke_x at loop cycle poke_cyc (must be ignored).
  task automatic run_op(input logic [31:0] x, input int poke_cyc, input logic [31:0] poke_x);
    int     last_c;
    int     done_cnt;
    longint sum;
    longint v;
    for (int i = 0; i < G; i++) begin
      cap_p[i] = 1'b0; cap_s[i] = 1'b0; cap_d[i] = 1'b0; cap_n[i] = 1'b0;
    end
    last_c   = -100;
    done_cnt = 0;
    @(negedge clk);
    X         = x;
    start     = 1'b1;
    enc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", longint'(busy), 1);
    for (int c = 0; c < 200; c++) begin
      start = (c == poke_cyc);
      if (c == poke_cyc) X = poke_x;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          chk("done_latency", longint'(c - 1), longint'(last_c));
          chk("busy_in_done", longint'(busy), 0);
        end
      end
      if (enc_valid) begin
        cap_p[Index] = 1'b1;
        cap_s[Index] = Single;
        cap_d[Index] = Double;
        cap_n[Index] = Negative;
        chk("last_flag", longint'(Last), longint'(Index == 4'd15));
        if (Last) last_c = c;
      end
      if (done_cnt > 0 && c > last_c + 20) break;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_once", longint'(done_cnt), 1);
    chk("busy_after_done", longint'(busy), 0);
    chk("valid_after_done", longint'(enc_valid), 0);
    sum = 0;
    for (int i = 0; i < G; i++) begin
      v = cap_s[i] ? 64'sd1 : (cap_d[i] ? 64'sd2 : 64'sd0);
      if (cap_n[i]) v = -v;
      sum += v * (64'sd1 <<< (2 * i));
    end
    chk($sformatf("digit_sum_x%08h", x), sum, longint'($signed(x)));
  endtask

  initial begin
    logic exp_p;

    rst       = 1'b1;
    start     = 1'b0;
    enc_ready = 1'b0;
    X         = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("idle");

    // X = 10
    vecs.push_back('{32'h0000000A, 0,  1'b0, 1'b1, 1'b1});
    vecs.push_back('{32'h0000000A, 1,  1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'h0000000A, 2,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'h0000000A, 3,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h0000000A, 15, 1'b0, 1'b0, 1'b0});
    // X = -1
    vecs.push_back('{32'hFFFFFFFF, 0,  1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'hFFFFFFFF, 1,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'hFFFFFFFF, 7,  1'b0, 1'b0, 1'b1});
    vecs.push_back('{32'hFFFFFFFF, 15, 1'b0, 1'b0, 1'b1});
    // X = -2^31
    vecs.push_back('{32'h80000000, 0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 14, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{32'h80000000, 15, 1'b0, 1'b1, 1'b1});
    // X = -3
    vecs.push_back('{32'hFFFFFFFD, 0,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{32'hFFFFFFFD, 1,  1'b1, 1'b0, 1'b1});
    vecs.push_back('{32'hFFFFFFFD, 2,  1'b0, 1'b0, 1'b1});
    // X = 6
    vecs.push_back('{32'h00000006, 0,  1'b0, 1'b1, 1'b1});
    vecs.push_back('{32'h00000006, 1,  1'b0, 1'b1, 1'b0});
    vecs.push_back('{32'h00000006, 2,  1'b0, 1'b0, 1'b0});

    for (int k = 0; k < vecs.size(); k++) begin
      if (k == 0 || vecs[k].x != vecs[k-1].x) run_op(vecs[k].x, -1, 32'h0);
`ifdef ZERO_SKIP_EN
      exp_p = vecs[k].s | vecs[k].d | (vecs[k].idx == G - 1);
`else
      exp_p = 1'b1;
`endif
      chk($sformatf("x%08h_i%0d_present", vecs[k].x, vecs[k].idx),
          longint'(cap_p[vecs[k].idx]), longint'(exp_p));
      if (exp_p) begin
        chk($sformatf("x%08h_i%0d_single", vecs[k].x, vecs[k].idx),
            longint'(cap_s[vecs[k].idx]), longint'(vecs[k].s));
        chk($sformatf("x%08h_i%0d_double", vecs[k].x, vecs[k].idx),
            longint'(cap_d[vecs[k].idx]), longint'(vecs[k].d));
        chk($sformatf("x%08h_i%0d_negative", vecs[k].x, vecs[k].idx),
            longint'(cap_n[vecs[k].idx]), longint'(vecs[k].n));
      end
    end

    // Start pulsed while busy with a different X must be ignored
    run_op(32'h0000000A, 2, 32'h80000000);
    chk("poke_i2_single", longint'(cap_s[2]), 1);
    chk("poke_i15_double", longint'(cap_d[15]), 0);

    // Backpressure: hold enc_ready low for 3 cycles while digit 1 is presented
    @(negedge clk);
    X = 32'h0000000A; start = 1'b1; enc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bp_first_valid", longint'(enc_valid), 1);
    chk("bp_first_index", longint'(Index), 0);
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      enc_ready = 1'b0;
      chk($sformatf("bp_hold%0d_index", r),  longint'(Index),     1);
      chk($sformatf("bp_hold%0d_valid", r),  longint'(enc_valid), 1);
      chk($sformatf("bp_hold%0d_single", r), longint'(Single),    1);
      chk($sformatf("bp_hold%0d_double", r), longint'(Double),    0);
      chk($sformatf("bp_hold%0d_neg", r),    longint'(Negative),  1);
      @(negedge clk);
    end
    chk("bp_still_index", longint'(Index), 1);
    enc_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_index", longint'(Index), 2);
    chk("bp_resume_single", longint'(Single), 1);
    chk("bp_resume_neg", longint'(Negative), 0);
    begin
      int waited;
      waited = 0;
      while (!done && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      chk("bp_done_seen", longint'(done), 1);
    end
    @(negedge clk);

    // Asynchronous reset in the middle of an encode
    X = 32'h0000000A; start = 1'b1; enc_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_reset_index", longint'(Index), 1);
    chk("pre_reset_busy", longint'(busy), 1);
    #1 rst = 1'b1;
    #1 chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
